// File: rtl/gpio_port_irq_if.sv
// CPU-side register bus for the GPIO block: select, word index, strobes and data.
// The CPU drives the master side; the peripheral answers on rdata.
interface gpio_port_irq_if;
    logic        sel;
    logic [3:0]  reg_idx;
    logic [31:0] wdata;
    logic        wstrb;
    logic        rstrb;
    logic [31:0] rdata;

    modport master (output sel, reg_idx, wdata, wstrb, rstrb, input rdata);
    modport slave  (input sel, reg_idx, wdata, wstrb, rstrb, output rdata);
endinterface

// File: rtl/gpio_port_irq.sv
// Parametrised GPIO port: synchronised and debounced inputs, atomic output updates,
// per-channel edge capture into a write-1-to-clear status register with an OR'd irq.
module gpio_port_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int CNT_BITS        = 16
) (
    input  logic             clk,
    input  logic             resetq,
    gpio_port_irq_if.slave   bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);
    // A threshold of 1 makes the filter a plain one-cycle register stage.
    localparam int          THRESH   = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam logic [31:0] THRESH_W = 32'(THRESH);

    localparam logic [3:0] REG_IN      = 4'd0;
    localparam logic [3:0] REG_OUT     = 4'd1;
    localparam logic [3:0] REG_DIR     = 4'd2;
    localparam logic [3:0] REG_SET     = 4'd3;
    localparam logic [3:0] REG_CLR     = 4'd4;
    localparam logic [3:0] REG_TGL     = 4'd5;
    localparam logic [3:0] REG_RISE_EN = 4'd6;
    localparam logic [3:0] REG_FALL_EN = 4'd7;
    localparam logic [3:0] REG_STATUS  = 4'd8;

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    sync_d [SYNC_STAGES];
    logic [CNT_BITS-1:0] cnt_q  [WIDTH];
    logic [CNT_BITS-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0]    filt_q, filt_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [WIDTH-1:0]    dir_q, dir_d;
    logic [WIDTH-1:0]    rise_en_q, rise_en_d;
    logic [WIDTH-1:0]    fall_en_q, fall_en_d;
    logic [WIDTH-1:0]    status_q, status_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         rd_val;
    logic [WIDTH-1:0]    wd, sync_s, rise_ev, fall_ev;
    logic                wr_en, rd_en;
    logic                unused_wdata;

    assign wr_en        = bus.sel & bus.wstrb;
    assign rd_en        = bus.sel & bus.rstrb;
    assign wd           = bus.wdata[WIDTH-1:0];
    assign unused_wdata = ^bus.wdata;
    assign sync_s       = sync_q[SYNC_STAGES-1];

    // Raw pads only ever reach the first synchroniser flop.
    always_comb begin
        sync_d[0] = pin_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != filt_q[i]) begin
                if ((32'(cnt_q[i]) + 32'd1) >= THRESH_W) begin
                    filt_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

    assign rise_ev = filt_d & ~filt_q & rise_en_q;
    assign fall_ev = ~filt_d & filt_q & fall_en_q;

    always_comb begin
        rd_val = '0;
        case (bus.reg_idx)
            REG_IN:      rd_val = 32'(filt_q);
            REG_OUT:     rd_val = 32'(out_q);
            REG_DIR:     rd_val = 32'(dir_q);
            REG_RISE_EN: rd_val = 32'(rise_en_q);
            REG_FALL_EN: rd_val = 32'(fall_en_q);
            REG_STATUS:  rd_val = 32'(status_q);
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q;
        rdata_d   = rdata_q;
        if (wr_en) begin
            case (bus.reg_idx)
                REG_OUT:     out_d     = wd;
                REG_DIR:     dir_d     = wd;
                REG_SET:     out_d     = out_q | wd;
                REG_CLR:     out_d     = out_q & ~wd;
                REG_TGL:     out_d     = out_q ^ wd;
                REG_RISE_EN: rise_en_d = wd;
                REG_FALL_EN: fall_en_d = wd;
                REG_STATUS:  status_d  = status_q & ~wd;
                default:     ;
            endcase
        end
        // New events are OR'd in after the clear so they survive a same-cycle W1C.
        status_d = status_d | rise_ev | fall_ev;
        if (rd_en) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q    <= '0;
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
        end
    end

    assign pin_out   = out_q;
    assign pin_oe    = dir_q;
    assign irq       = |status_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_gpio_port_irq.sv
// Bench for gpio_port_irq: directed scenarios plus randomised bus/pin traffic,
// all checked against a window-based behavioural model of the port.
module tb_gpio_port_irq;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int THR  = 4;

    logic         clk    = 1'b0;
    logic         resetq = 1'b0;
    logic [W-1:0] pin_in = '1;
    logic [W-1:0] pin_out, pin_oe;
    logic         irq;
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           chk_en  = 1'b0;

    gpio_port_irq_if bus();

    gpio_port_irq #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(THR), .CNT_BITS(16)
    ) dut (
        .clk(clk), .resetq(resetq), .bus(bus.slave),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the filtered value flips once the last THR synchronised
    // samples all disagree with it; samples are the pad values SYNC edges old.
    logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status, m_filt, m_nf, m_s, m_wd, m_ev;
    logic [31:0]  m_rdata;
    logic [W-1:0] pq[$];
    logic [W-1:0] sq[$];
    bit           m_all;

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'(m_filt);
            4'd1:    return 32'(m_out);
            4'd2:    return 32'(m_dir);
            4'd6:    return 32'(m_rise);
            4'd7:    return 32'(m_fall);
            4'd8:    return 32'(m_status);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!resetq) begin
            m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0;
            m_status = '0; m_filt = '0; m_rdata = '0;
            pq.delete();
            repeat (SYNC) pq.push_back('0);
            sq.delete();
        end else begin
            m_s = pq.pop_front();
            pq.push_back(pin_in);
            sq.push_back(m_s);
            if (sq.size() > THR) void'(sq.pop_front());
            m_nf = m_filt;
            if (sq.size() == THR) begin
                for (int i = 0; i < W; i++) begin
                    m_all = 1'b1;
                    foreach (sq[k]) if (sq[k][i] == m_filt[i]) m_all = 1'b0;
                    if (m_all) m_nf[i] = ~m_filt[i];
                end
            end
            m_ev = (m_nf & ~m_filt & m_rise) | (~m_nf & m_filt & m_fall);
            m_wd = bus.wdata[W-1:0];
            if (bus.sel && bus.rstrb) m_rdata = m_read(bus.reg_idx);
            if (bus.sel && bus.wstrb) begin
                case (bus.reg_idx)
                    4'd1: m_out = m_wd;
                    4'd2: m_dir = m_wd;
                    4'd3: m_out = m_out | m_wd;
                    4'd4: m_out = m_out & ~m_wd;
                    4'd5: m_out = m_out ^ m_wd;
                    4'd6: m_rise = m_wd;
                    4'd7: m_fall = m_wd;
                    4'd8: m_status = m_status & ~m_wd;
                    default: ;
                endcase
            end
            m_status = m_status | m_ev;
            m_filt   = m_nf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pin_out", 32'(pin_out), 32'(m_out));
            chk("model_pin_oe",  32'(pin_oe),  32'(m_dir));
            chk("model_irq",     32'(irq),     32'(|m_status));
            chk("model_rdata",   bus.rdata,    m_rdata);
        end
    end

    task automatic bus_idle();
        bus.sel = 1'b0; bus.wstrb = 1'b0; bus.rstrb = 1'b0;
        bus.reg_idx = 4'd0; bus.wdata = 32'd0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] d);
        bus.sel = 1'b1; bus.wstrb = 1'b1; bus.rstrb = 1'b0;
        bus.reg_idx = idx; bus.wdata = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input logic [3:0] idx, output logic [31:0] d);
        bus.sel = 1'b1; bus.rstrb = 1'b1; bus.wstrb = 1'b0;
        bus.reg_idx = idx; bus.wdata = 32'd0;
        @(negedge clk);
        d = bus.rdata;
        bus_idle();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One reset edge, then the IN register must need the full sync+debounce latency.
    task automatic reset_latency(input string tag, input logic [W-1:0] exp_in);
        logic [31:0] v;
        resetq = 1'b0;
        @(negedge clk);
        chk({tag, "_rdata"},   bus.rdata,       32'd0);
        chk({tag, "_pin_out"}, 32'(pin_out),    32'd0);
        chk({tag, "_pin_oe"},  32'(pin_oe),     32'd0);
        chk({tag, "_irq"},     32'(irq),        32'd0);
        resetq = 1'b1;
        rd(4'd0, v); chk({tag, "_in_edge1"}, v, 32'd0);
        idle(4);
        rd(4'd0, v); chk({tag, "_in_edge6"}, v, 32'd0);
        rd(4'd0, v); chk({tag, "_in_edge7"}, v, 32'(exp_in));
    endtask

    initial begin
        logic [31:0] v;
        logic [W-1:0] flip;
        bus_idle();
        resetq = 1'b0;
        pin_in = 8'hFF;
        @(negedge clk);
        chk_en = 1'b1;

        // 1: reset state and input latency
        reset_latency("rst", 8'hFF);
        rd(4'd8, v); chk("status_no_en", v, 32'd0);

        // 2: OUT register and atomic set/clear/toggle
        wr(4'd1, 32'h0F); chk("out_wr",  32'(pin_out), 32'h0F);
        wr(4'd3, 32'h30); chk("out_set", 32'(pin_out), 32'h3F);
        wr(4'd4, 32'h03); chk("out_clr", 32'(pin_out), 32'h3C);
        wr(4'd5, 32'h81); chk("out_tgl", 32'(pin_out), 32'hBD);
        rd(4'd3, v); chk("rd_set0", v, 32'd0);
        rd(4'd4, v); chk("rd_clr0", v, 32'd0);
        rd(4'd5, v); chk("rd_tgl0", v, 32'd0);
        rd(4'd1, v); chk("rd_out",  v, 32'hBD);
        wr(4'd2, 32'hFFFF_FFA5); chk("dir_oe", 32'(pin_oe), 32'hA5);
        rd(4'd2, v); chk("rd_dir_zext", v, 32'hA5);
        rd(4'd12, v); chk("rd_unmapped", v, 32'd0);

        // 3: rising-edge capture latency and W1C
        pin_in = 8'hFE; idle(8);
        wr(4'd6, 32'h01);
        pin_in = 8'hFF;
        idle(5); chk("rise_irq_edge5", 32'(irq), 32'd0);
        idle(1); chk("rise_irq_edge6", 32'(irq), 32'd1);
        rd(4'd8, v); chk("rise_status", v, 32'h01);
        wr(4'd8, 32'h01); chk("w1c_irq_low", 32'(irq), 32'd0);

        // 4: short pulse rejected, long pulse accepted both ways
        pin_in = 8'hFD; idle(8);
        wr(4'd6, 32'h02); wr(4'd7, 32'h02);
        pin_in[1] = 1'b1; idle(3); pin_in[1] = 1'b0; idle(8);
        rd(4'd0, v); chk("short_pulse_in", v, 32'hFD);
        rd(4'd8, v); chk("short_pulse_status", v, 32'd0);
        pin_in[1] = 1'b1; idle(4); pin_in[1] = 1'b0;
        idle(1); chk("pulse_irq_e5", 32'(irq), 32'd0);
        idle(1); chk("pulse_irq_e6", 32'(irq), 32'd1);
        wr(4'd8, 32'h02); chk("pulse_w1c", 32'(irq), 32'd0);
        idle(2); chk("fall_irq_e9", 32'(irq), 32'd0);
        idle(1); chk("fall_irq_e10", 32'(irq), 32'd1);
        rd(4'd8, v); chk("fall_status", v, 32'h02);
        rd(4'd0, v); chk("fall_in", v, 32'hFD);
        wr(4'd8, 32'h02);

        // 5: a new event beats a same-cycle W1C on the same bit
        wr(4'd7, 32'h04);
        pin_in[2] = 1'b0; idle(7);
        rd(4'd8, v); chk("fall2_status", v, 32'h04);
        pin_in[2] = 1'b1; idle(8);
        chk("rise2_not_enabled_irq", 32'(irq), 32'd1);
        pin_in[2] = 1'b0; idle(5);
        wr(4'd8, 32'h04); chk("event_beats_w1c_irq", 32'(irq), 32'd1);
        rd(4'd8, v); chk("event_beats_w1c_status", v, 32'h04);
        wr(4'd8, 32'h04); chk("w1c2_irq", 32'(irq), 32'd0);

        // 6: reset in the middle of a debounce run
        wr(4'd2, 32'hFF); wr(4'd7, 32'h80);
        pin_in[7] = 1'b0; idle(7);
        rd(4'd8, v); chk("pre_rst_status", v, 32'h80);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        chk("pre_rst_oe", 32'(pin_oe), 32'hFF);
        pin_in[3] = 1'b0; idle(4);
        reset_latency("mid_db", 8'h71);

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            flip = '0;
            for (int b = 0; b < W; b++) if ($urandom_range(0, 11) == 0) flip[b] = 1'b1;
            pin_in      = pin_in ^ flip;
            bus.sel     = 1'($urandom_range(0, 1));
            bus.wstrb   = ($urandom_range(0, 2) == 0);
            bus.rstrb   = 1'($urandom_range(0, 1));
            bus.reg_idx = 4'($urandom_range(0, 15));
            bus.wdata   = $urandom();
            resetq      = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        bus_idle();
        resetq = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
